// File: rtl/jk_pkg.sv
// jk_pkg: JK command encodings and the helper that picks a command for a cur->nxt cell transition
package jk_pkg;
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;
    function automatic logic [1:0] jk_cmd(input logic cur, input logic nxt);
        return (cur == nxt) ? JK_HOLD : (nxt ? JK_SET : JK_RESET);
    endfunction
endpackage

// File: rtl/jk_cell.sv
// jk_cell: one JK flip-flop bit with async active-high reset and complementary output
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_n
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= 1'b0;
        else     q <= (j & k) ? ~q : j ? 1'b1 : k ? 1'b0 : q;
    assign q_n = ~q;
endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MOD up/down counter with clamped parallel load, built from JK cells
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             input_clock1_c_1,
    input  logic             input_input_switch2_reset_2,
    input  logic             input_input_switch3_enable_3,
    input  logic             input_input_switch4_up_down_4,
    input  logic             input_input_switch5_load_5,
    input  logic [WIDTH-1:0] input_input_bus6_d_6,
    output logic [WIDTH-1:0] output_led1_q_7,
    output logic [WIDTH-1:0] output_led2_q_n_8,
    output logic             output_led3_tc_9
);
    if (WIDTH < 2 || WIDTH > 16 || MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_param
        $error("jk_mod_counter: WIDTH or MOD out of range");
    end
    logic             clk, rst, en, up, ld;
    logic [WIDTH-1:0] q, q_n, dc, wv, j, k, m;
    logic             at_max, at_zero, over, wrap;
    assign clk     = input_clock1_c_1;
    assign rst     = input_input_switch2_reset_2;
    assign en      = input_input_switch3_enable_3;
    assign up      = input_input_switch4_up_down_4;
    assign ld      = input_input_switch5_load_5;
    assign at_max  = int'(q) == MOD - 1;
    assign at_zero = q == '0;
    assign over    = int'(q) >= MOD;
    assign dc      = int'(input_input_bus6_d_6) >= MOD ? WIDTH'(MOD - 1) : input_input_bus6_d_6;
    assign wrap    = up ? (at_max | over) : (at_zero | over);
    assign wv      = up ? '0 : WIDTH'(MOD - 1);
    always_comb begin
        j = '0;
        k = '0;
        m = '0;
        if (ld) begin
            j = dc;
            k = ~dc;
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                m = (WIDTH'(1) << i) - WIDTH'(1);
                {j[i], k[i]} = wrap ? jk_cmd(q[i], wv[i])
                                    : {2{up ? ((q & m) == m) : ((q & m) == '0)}};
            end
        end
    end
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (.clk(clk), .rst(rst), .j(j[g]), .k(k[g]), .q(q[g]), .q_n(q_n[g]));
    end
    assign output_led1_q_7   = q;
    assign output_led2_q_n_8 = q_n;
    assign output_led3_tc_9  = en & ~ld & ~rst & (up ? at_max : at_zero);
endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: scoreboard bench with an arithmetic reference model of the modulo counter
module tb_jk_mod_counter;
    localparam int W = 4;
    localparam int M = 10;
    logic         clk = 1'b0, rst = 1'b1, en = 1'b0, up = 1'b0, ld = 1'b0;
    logic [W-1:0] d = '0, q, qn;
    logic         tc;
    typedef struct { int q; bit tc; } exp_t;
    exp_t sb[$];
    int   m = 0, n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(W), .MOD(M)) dut (
        .input_clock1_c_1              (clk),
        .input_input_switch2_reset_2   (rst),
        .input_input_switch3_enable_3  (en),
        .input_input_switch4_up_down_4 (up),
        .input_input_switch5_load_5    (ld),
        .input_input_bus6_d_6          (d),
        .output_led1_q_7               (q),
        .output_led2_q_n_8             (qn),
        .output_led3_tc_9              (tc)
    );

    task automatic step(input bit r, input bit e, input bit u, input bit l, input int dv);
        @(negedge clk);
        rst = r; en = e; up = u; ld = l; d = W'(dv);
        if (r) m = 0;
        sb.push_back(exp_t'{m, e && !l && !r && (u ? m == M - 1 : m == 0)});
        if (r)      m = 0;
        else if (l) m = dv >= M ? M - 1 : dv;
        else if (e) m = u ? (m == M - 1 ? 0 : m + 1) : (m == 0 ? M - 1 : m - 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp += 3;
            if (q !== W'(e.q)) begin
                n_bad++;
                $display("FAIL q @%0t: got %0d want %0d", $time, q, e.q);
            end
            if (qn !== ~W'(e.q)) begin
                n_bad++;
                $display("FAIL q_n @%0t: got %h want %h", $time, qn, ~W'(e.q));
            end
            if (tc !== e.tc) begin
                n_bad++;
                $display("FAIL tc @%0t: got %b want %b (q=%0d)", $time, tc, e.tc, e.q);
            end
        end
    end

    initial begin
        repeat (3) step(1, 1, 1, 0, 0);
        repeat (3) step(0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 8);
        repeat (22) step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 5);
        step(0, 1, 0, 1, 13);
        step(0, 1, 1, 1, 9);
        step(0, 1, 1, 1, 15);
        step(0, 0, 0, 1, 4);
        repeat (5) step(0, 0, $urandom_range(0, 1), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, i % 2 == 0, 0, 0);
        step(0, 0, 0, 1, 6);
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (3) step(0, 1, 1, 0, 0);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 15));
        step(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #5;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
